// File: rtl/store_branch_encoder_pkg.sv
// Shared types, opcodes, instruction field positions and offset range check for store_branch_encoder.
package store_branch_encoder_pkg;

  typedef enum logic {FMT_S = 1'b0, FMT_SB = 1'b1} fmt_e;

  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam int OPC_LSB    = 0;
  localparam int IMM_LO_LSB = 7;
  localparam int F3_LSB     = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int IMM_HI_LSB = 25;

  // Offsets are sign-extended to this width before the range check, so xlen must stay below it.
  localparam int IMM_W = 128;

  function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input fmt_e fmt);
    logic [IMM_W-1:0] s_form;
    logic [IMM_W-1:0] sb_form;
    s_form  = {{(IMM_W-12){imm[11]}}, imm[11:0]};
    sb_form = {{(IMM_W-13){imm[12]}}, imm[12:1], 1'b0};
    return (fmt == FMT_S) ? (imm == s_form) : (imm == sb_form);
  endfunction

endpackage

// File: rtl/store_branch_encoder_fifo2.sv
// Two-entry in-order valid/ready buffer; an accepted word is visible at rd_data the next cycle.
// wr_ready depends only on registered occupancy, so there is no rd_ready -> wr_ready path.
module store_branch_encoder_fifo2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [width-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [width-1:0] rd_data
);

  logic [1:0]       count;
  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic             push;
  logic             pop;

  assign wr_ready = (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign rd_data  = head;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      // push is never legal at count 2, so head/tail only need these cases
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        head <= wr_data;
      end else if (pop && count == 2'd2) begin
        head <= tail;
      end
      if (push && count == 2'd1 && !pop) begin
        tail <= wr_data;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/store_branch_encoder.sv
// Packs fields into 32-bit S/SB words tagged with a running address; 1-cycle latency, 2-entry buffer,
// in_ready from occupancy only. Define RANGE_CHECK_EN to flag out-of-range offsets on out_err.
import store_branch_encoder_pkg::*;

module store_branch_encoder #(
  parameter int              xlen      = 64,
  parameter logic [xlen-1:0] base_addr = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [xlen-1:0] in_imm,
  input  logic            addr_load,
  input  logic [xlen-1:0] addr_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [xlen-1:0] out_addr,
  output logic            out_err
);

  typedef struct packed {
    logic            err;
    logic [xlen-1:0] addr;
    logic [31:0]     instr;
  } entry_t;

  fmt_e            fmt;
  logic [31:0]     instr;
  logic            err;
  logic            accept;
  logic [xlen-1:0] counter;
  logic [xlen-1:0] word_addr;
  entry_t          wr_entry;
  entry_t          rd_entry;

  assign fmt = fmt_e'(in_fmt);

  always_comb begin
    instr = '0;
    instr[OPC_LSB +: 7] = in_opcode;
    instr[F3_LSB  +: 3] = in_funct3;
    instr[RS1_LSB +: 5] = in_rs1;
    instr[RS2_LSB +: 5] = in_rs2;
    if (fmt == FMT_S) begin
      instr[IMM_HI_LSB +: 7] = in_imm[11:5];
      instr[IMM_LO_LSB +: 5] = in_imm[4:0];
    end else begin
      instr[31]                  = in_imm[12];
      instr[IMM_HI_LSB +: 6]     = in_imm[10:5];
      instr[IMM_LO_LSB + 1 +: 4] = in_imm[4:1];
      instr[IMM_LO_LSB]          = in_imm[11];
    end
  end

`ifdef RANGE_CHECK_EN
  logic [IMM_W-1:0] imm_ext;
  assign imm_ext = {{(IMM_W-xlen){in_imm[xlen-1]}}, in_imm};
  assign err     = !imm_fits(imm_ext, fmt);
`else
  // Upper offset bits only matter to the range check.
  logic unused_imm;
  assign unused_imm = ^in_imm[xlen-1:13];
  assign err        = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign word_addr = addr_load ? addr_value : counter;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= base_addr;
    end else if (accept) begin
      counter <= word_addr + xlen'(4);
    end else if (addr_load) begin
      counter <= addr_value;
    end
  end

  assign wr_entry = '{err: err, addr: word_addr, instr: instr};

  store_branch_encoder_fifo2 #(.width($bits(entry_t))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_entry)
  );

  assign out_instr = rd_entry.instr;
  assign out_addr  = rd_entry.addr;
  assign out_err   = rd_entry.err;

endmodule

// File: tb/tb_store_branch_encoder.sv
// Self-checking bench for store_branch_encoder: directed vectors plus randomized traffic against a queue model.
import store_branch_encoder_pkg::*;

module tb_store_branch_encoder;

  localparam logic [63:0] BASE = 64'h80;
`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_fmt = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [63:0] in_imm = '0;
  logic        addr_load = 1'b0;
  logic [63:0] addr_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        out_err;

  int          checks = 0;
  int          errors = 0;
  word_t       exp_q[$];
  word_t       got_q[$];
  logic [63:0] m_addr = BASE;

  store_branch_encoder #(.xlen(64), .base_addr(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_load(addr_load), .addr_value(addr_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Field placement computed arithmetically from the instruction format tables.
  function automatic logic [31:0] ref_encode(logic fmt, logic [6:0] opc, logic [2:0] f3,
                                             logic [4:0] r1, logic [4:0] r2, logic [63:0] imm);
    longint unsigned u = imm;
    longint unsigned w;
    w = longint'(opc) + longint'(f3) * (64'd1 << 12) + longint'(r1) * (64'd1 << 15)
      + longint'(r2) * (64'd1 << 20);
    if (!fmt)
      w = w + ((u / 32) % 128) * (64'd1 << 25) + (u % 32) * (64'd1 << 7);
    else
      w = w + ((u / 4096) % 2) * (64'd1 << 31) + ((u / 32) % 64) * (64'd1 << 25)
            + ((u / 2) % 16) * (64'd1 << 8) + ((u / 2048) % 2) * (64'd1 << 7);
    return w[31:0];
  endfunction

  function automatic logic ref_err(logic fmt, logic [63:0] imm);
    longint s = longint'(imm);
    logic bad;
    if (!fmt) bad = !(s >= -2048 && s <= 2047);
    else      bad = !(s >= -4096 && s <= 4095 && (s % 2) == 0);
    return RC && bad;
  endfunction

  function automatic logic [63:0] rand_imm(logic fmt);
    longint v = longint'($urandom_range(0, 8191)) - 4096;
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return 64'(v);
      default: return fmt ? 64'(v & -2) : 64'(v / 2);
    endcase
  endfunction

  // Advance one clock, recording handshakes into the model first.
  task automatic step();
    logic [63:0] a;
    if (rst) begin
      exp_q.delete();
      m_addr = BASE;
    end else begin
      if (in_valid && in_ready) begin
        a = addr_load ? addr_value : m_addr;
        exp_q.push_back('{instr: ref_encode(in_fmt, in_opcode, in_funct3, in_rs1, in_rs2, in_imm),
                          addr: a, err: ref_err(in_fmt, in_imm)});
        m_addr = a + 64'd4;
      end else if (addr_load) begin
        m_addr = addr_value;
      end
      if (out_valid && out_ready) got_q.push_back('{instr: out_instr, addr: out_addr, err: out_err});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic fmt, input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [63:0] imm, input logic load, input logic [63:0] lval);
    bit done = 0;
    in_fmt = fmt; in_opcode = opc; in_funct3 = f3; in_rs1 = r1; in_rs2 = r2; in_imm = imm;
    addr_load = load; addr_value = lval; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    addr_load = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: in_ready never high within 20 cycles");
    end
  endtask

  task automatic send_rand();
    logic f = 1'($urandom_range(0, 1));
    send(f, f ? OPCODE_BRANCH : OPCODE_STORE, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), rand_imm(f), 1'b0, 64'd0);
  endtask

  task automatic flush();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_valid; i++) step();
    step();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_instr, out_addr, out_err, in_ready} !== {1'b0, 32'h0, 64'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%h a=%h e=%b r=%b want v=0 i=0 a=0 e=0 r=1",
               out_valid, out_instr, out_addr, out_err, in_ready);
    end
  endtask

  task automatic test_s_type();
    out_ready = 1'b1;
    send(1'b0, 7'b0100011, 3'b011, 5'd2, 5'd5, -64'sd8, 1'b0, 64'd0);
    checks++;
    if ({out_valid, out_instr, out_addr, out_err} !== {1'b1, 32'hFE513C23, BASE, 1'b0}) begin
      errors++;
      $display("FAIL s_vector: got v=%b i=%h a=%h e=%b want v=1 i=fe513c23 a=%h e=0",
               out_valid, out_instr, out_addr, out_err, BASE);
    end
    flush();
  endtask

  task automatic test_sb_type();
    out_ready = 1'b1;
    send(1'b1, 7'b1100011, 3'b000, 5'd1, 5'd2, 64'd16, 1'b0, 64'd0);
    checks++;
    if ({out_valid, out_instr, out_addr} !== {1'b1, 32'h00208863, BASE + 64'd4}) begin
      errors++;
      $display("FAIL sb_vector_16: got v=%b i=%h a=%h want 1 00208863 %h", out_valid, out_instr, out_addr, BASE + 64'd4);
    end
    send(1'b1, 7'b1100011, 3'b000, 5'd0, 5'd0, -64'sd4096, 1'b0, 64'd0);
    checks++;
    if ({out_valid, out_instr, out_addr, out_err} !== {1'b1, 32'h80000063, BASE + 64'd8, 1'b0}) begin
      errors++;
      $display("FAIL sb_vector_m4096: got v=%b i=%h a=%h e=%b want 1 80000063 %h 0",
               out_valid, out_instr, out_addr, out_err, BASE + 64'd8);
    end
    flush();
  endtask

  task automatic test_range();
    out_ready = 1'b1;
    send(1'b0, OPCODE_STORE, 3'b010, 5'd3, 5'd4, 64'd2048, 1'b0, 64'd0);
    checks++;
    if ({out_valid, out_err, out_instr[31:25]} !== {1'b1, RC, 7'h40}) begin
      errors++;
      $display("FAIL range_s_2048: got v=%b e=%b hi=%h want v=1 e=%b hi=40", out_valid, out_err, out_instr[31:25], RC);
    end
    send(1'b1, OPCODE_BRANCH, 3'b001, 5'd3, 5'd4, 64'd3, 1'b0, 64'd0);
    checks++;
    if ({out_valid, out_err} !== {1'b1, RC}) begin
      errors++;
      $display("FAIL range_sb_odd: got v=%b e=%b want v=1 e=%b", out_valid, out_err, RC);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_rand();
    send_rand();
    checks++;
    if ({in_ready, out_valid, out_instr} !== {1'b0, 1'b1, exp_q[0].instr}) begin
      errors++;
      $display("FAIL b2b_full: got r=%b v=%b i=%h want r=0 v=1 i=%h", in_ready, out_valid, out_instr, exp_q[0].instr);
    end
    in_valid = 1'b1;
    step();
    step();
    checks++;
    if ({in_ready, out_valid, out_instr, out_addr} !== {1'b0, 1'b1, exp_q[0].instr, exp_q[0].addr}) begin
      errors++;
      $display("FAIL b2b_hold: got r=%b v=%b i=%h a=%h want r=0 v=1 i=%h a=%h",
               in_ready, out_valid, out_instr, out_addr, exp_q[0].instr, exp_q[0].addr);
    end
    out_ready = 1'b1;
    send_rand();
    for (int i = 0; i < 10 && got_q.size() < 3; i++) step();
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d words (model %0d) want 3", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    flush();
  endtask

  task automatic test_addr_load();
    logic [63:0] want [0:6] = '{64'h1000, 64'h1004, 64'h1008, 64'h2000, 64'h2004,
                                64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    out_ready = 1'b1;
    addr_load = 1'b1; addr_value = 64'h1000;
    step();
    addr_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        addr_load = 1'b1; addr_value = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        addr_load = 1'b0;
      end
      if (i == 3) send(1'b0, OPCODE_STORE, 3'd0, 5'd1, 5'd1, 64'd0, 1'b1, 64'h2000);
      else        send_rand();
      checks++;
      if ({out_valid, out_addr} !== {1'b1, want[i]}) begin
        errors++;
        $display("FAIL addr_seq%0d: got v=%b a=%h want v=1 a=%h", i, out_valid, out_addr, want[i]);
      end
    end
    flush();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_rand();
    send_rand();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, out_instr, out_err} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got v=%b r=%b i=%h e=%b want v=0 r=1 i=0 e=0", out_valid, in_ready, out_instr, out_err);
    end
    out_ready = 1'b1;
    send_rand();
    checks++;
    if ({out_valid, out_addr} !== {1'b1, BASE}) begin
      errors++;
      $display("FAIL reset_mid_addr: got v=%b a=%h want v=1 a=%h", out_valid, out_addr, BASE);
    end
    flush();
  endtask

  task automatic test_random();
    word_t prev = '0;
    logic  prev_hold = 1'b0;
    int    occ;
    for (int c = 0; c < 400; c++) begin
      occ = exp_q.size() - got_q.size();
      checks++;
      if ({in_ready, out_valid} !== {occ < 2, occ > 0}) begin
        errors++;
        $display("FAIL rand_flags c%0d: got r=%b v=%b want r=%b v=%b", c, in_ready, out_valid, occ < 2, occ > 0);
      end
      if (prev_hold) begin
        checks++;
        if ({out_valid, out_instr, out_addr, out_err} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL rand_stable c%0d: got %h want %h", c, {out_instr, out_addr, out_err}, prev);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_fmt    = 1'($urandom_range(0, 1));
      in_opcode = in_fmt ? OPCODE_BRANCH : OPCODE_STORE;
      in_funct3 = 3'($urandom_range(0, 7));
      in_rs1    = 5'($urandom_range(0, 31));
      in_rs2    = 5'($urandom_range(0, 31));
      in_imm    = rand_imm(in_fmt);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_value = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom & 32'hFFFF_FFFC};
      prev_hold = out_valid && !out_ready;
      prev = '{instr: out_instr, addr: out_addr, err: out_err};
      step();
    end
    in_valid = 1'b0;
    addr_load = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d words want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_s_type();
    test_sb_type();
    test_range();
    test_back_to_back();
    test_addr_load();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
